// File: rtl/detector_jogada.sv
// detector_jogada: conditions four raw push-buttons into one clean play.
// Two-flop synchronizer, stability-counter debounce, then a Moore FSM that
// captures a one-hot code on press and pulses jogada_feita on release
// (or jogada_invalida when the press had several buttons down).
module detector_jogada #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [3:0] botoes,
  output logic [3:0] jogada,
  output logic       jogada_feita,
  output logic       jogada_invalida,
  output logic [3:0] db_botoes,
  output logic [3:0] db_estado
);

  localparam logic [2:0] OCIOSO        = 3'd0;
  localparam logic [2:0] ESPERA_LIVRE  = 3'd1;
  localparam logic [2:0] ESPERA_APERTO = 3'd2;
  localparam logic [2:0] REGISTRA      = 3'd3;
  localparam logic [2:0] ESPERA_SOLTA  = 3'd4;
  localparam logic [2:0] EMITE         = 3'd5;
  localparam logic [2:0] INVALIDA      = 3'd6;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       db_q;
  logic [2:0]       state_q, state_d;
  logic [3:0]       jogada_q, jogada_d;
  logic             inv_q, inv_d;
  logic             onehot;

  // Synchronize, then accept a new vector only after it held CNT_MAX+1 samples
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 4'b0;
      sync2_q <= 4'b0;
      cand_q  <= 4'b0;
      cnt_q   <= '0;
      db_q    <= 4'b0;
    end else begin
      sync1_q <= botoes;
      sync2_q <= sync1_q;
      if (sync2_q != cand_q) begin
        cand_q <= sync2_q;
        cnt_q  <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        db_q <= cand_q;
      end
    end
  end

  // A code is a legal play only if exactly one button is down
  assign onehot = (db_q != 4'b0) && ((db_q & (db_q - 4'd1)) == 4'b0);

  // Next-state logic; dropping habilita aborts any play in progress silently
  always_comb begin
    state_d  = state_q;
    jogada_d = jogada_q;
    inv_d    = inv_q;
    if (state_q != OCIOSO && !habilita) begin
      state_d = OCIOSO;
    end else begin
      case (state_q)
        OCIOSO:        if (habilita) state_d = (db_q == 4'b0) ? ESPERA_APERTO : ESPERA_LIVRE;
        ESPERA_LIVRE:  if (db_q == 4'b0) state_d = ESPERA_APERTO;
        ESPERA_APERTO: if (db_q != 4'b0) state_d = REGISTRA;
        REGISTRA: begin
          if (onehot) begin
            jogada_d = db_q;
            inv_d    = 1'b0;
          end else begin
            inv_d    = 1'b1;
          end
          state_d = ESPERA_SOLTA;
        end
        ESPERA_SOLTA:  if (db_q == 4'b0) state_d = inv_q ? INVALIDA : EMITE;
        EMITE,
        INVALIDA:      state_d = ESPERA_APERTO;
        default:       state_d = OCIOSO;
      endcase
    end
  end

  // FSM and captured-play registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= OCIOSO;
      jogada_q <= 4'b0;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      jogada_q <= jogada_d;
      inv_q    <= inv_d;
    end
  end

  assign jogada          = jogada_q;
  assign jogada_feita    = (state_q == EMITE);
  assign jogada_invalida = (state_q == INVALIDA);
  assign db_botoes       = db_q;
  assign db_estado       = {1'b0, state_q};

endmodule

// File: tb/tb_detector_jogada.sv
// Bench for detector_jogada: directed scenarios plus random button traffic,
// all checked every cycle against a play-level reference model.
module tb_detector_jogada;

  localparam int DC = 4;
  localparam int HL = DC + 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       habilita;
  logic [3:0] botoes;
  logic [3:0] jogada;
  logic       jogada_feita;
  logic       jogada_invalida;
  logic [3:0] db_botoes;
  logic [3:0] db_estado;

  detector_jogada #(.DEBOUNCE_CYCLES(DC), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .habilita(habilita), .botoes(botoes),
    .jogada(jogada), .jogada_feita(jogada_feita), .jogada_invalida(jogada_invalida),
    .db_botoes(db_botoes), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Debounce rule: a button sample taken at edge n appears on db_botoes at
  // edge n+2+DC if it was identical at DC+1 consecutive edges.
  // Play rule: what the player is doing, as named phases.
  typedef enum int {IDLE, GUARD, READY, CAPT, HELD, PULSE} mode_t;

  logic [3:0] hist [HL];
  logic [3:0] m_db, m_jog;
  mode_t      mode;
  logic       bad;

  function automatic int est(input mode_t m, input logic b);
    case (m)
      IDLE:    return 0;
      GUARD:   return 1;
      READY:   return 2;
      CAPT:    return 3;
      HELD:    return 4;
      default: return b ? 6 : 5;
    endcase
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < HL; i++) hist[i] = 4'b0;
      m_db = 4'b0; m_jog = 4'b0; mode = IDLE; bad = 1'b0;
    end else begin
      logic       st;
      logic [3:0] old_db;
      old_db = m_db;
      for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = botoes;
      st = 1'b1;
      for (int i = 3; i <= 2 + DC; i++) if (hist[i] != hist[2]) st = 1'b0;
      if (st) m_db = hist[2];
      if (mode != IDLE && !habilita) mode = IDLE;
      else begin
        case (mode)
          IDLE:  if (habilita) mode = (old_db == 0) ? READY : GUARD;
          GUARD: if (old_db == 0) mode = READY;
          READY: if (old_db != 0) mode = CAPT;
          CAPT: begin
            if ($countones(old_db) == 1) begin m_jog = old_db; bad = 1'b0; end
            else bad = 1'b1;
            mode = HELD;
          end
          HELD:  if (old_db == 0) mode = PULSE;
          PULSE: mode = READY;
          default: mode = IDLE;
        endcase
      end
    end
  end

  task automatic check_all();
    chk("jogada", jogada, m_jog);
    chk("feita", jogada_feita, (mode == PULSE && !bad) ? 1 : 0);
    chk("invalida", jogada_invalida, (mode == PULSE && bad) ? 1 : 0);
    chk("db_botoes", db_botoes, m_db);
    chk("db_estado", db_estado, est(mode, bad));
  endtask

  // state-code change tracker for the sequence test
  logic       track = 1'b0;
  int         seq, nchg;
  logic [3:0] last_est;

  task automatic step(input logic h, input logic [3:0] b);
    habilita = h;
    botoes   = b;
    @(negedge clock);
    check_all();
    if (track && db_estado != last_est) begin
      seq = (seq << 4) | int'(db_estado);
      nchg++;
      last_est = db_estado;
    end
  endtask

  task automatic run(input logic h, input logic [3:0] b, input int n,
                     output int nf, output int ni, output int first);
    nf = 0; ni = 0; first = 0;
    for (int k = 1; k <= n; k++) begin
      step(h, b);
      if (jogada_feita) begin nf++; if (first == 0) first = k; end
      if (jogada_invalida) ni++;
    end
  endtask

  initial begin
    int nf, ni, first, nf2, ni2, f2;
    reset = 1'b1; habilita = 1'b0; botoes = 4'b0;
    repeat (3) @(negedge clock);
    chk("rst_jogada", jogada, 0);
    chk("rst_feita", jogada_feita, 0);
    chk("rst_inval", jogada_invalida, 0);
    chk("rst_db", db_botoes, 0);
    chk("rst_estado", db_estado, 0);
    check_all();
    reset = 1'b0;

    // clean press of 0100, estado sequence and release latency
    seq = 0; nchg = 0; last_est = 4'd0; track = 1'b1;
    run(1, 4'b0000, 3, nf, ni, first);
    run(1, 4'b0100, 20, nf, ni, first);
    chk("t1_press_pulses", nf + ni, 0);
    run(1, 4'b0000, 20, nf, ni, first);
    track = 1'b0;
    chk("t1_jogada", jogada, 4'b0100);
    chk("t1_npulse", nf, 1);
    chk("t1_latency", first, 8);
    chk("t1_ninv", ni, 0);
    chk("t1_nchg", nchg, 5);
    chk("t1_seq", seq, 'h23452);

    // bounce on bit0, then stable
    for (int i = 0; i < 12; i++) step(1, ((i / 2) % 2 == 0) ? 4'b0001 : 4'b0000);
    chk("t2_bounce_db", db_botoes, 0);
    first = 0;
    for (int k = 1; k <= 15; k++) begin
      step(1, 4'b0001);
      if (db_botoes == 4'b0001 && first == 0) first = k;
    end
    chk("t2_db_latency", first, 7);
    run(1, 4'b0001, 5, nf, ni, f2);
    chk("t2_no_early", nf + ni, 0);
    run(1, 4'b0000, 20, nf, ni, f2);
    chk("t2_npulse", nf, 1);
    chk("t2_jogada", jogada, 4'b0001);

    // two buttons together
    run(1, 4'b0011, 20, nf, ni, first);
    run(1, 4'b0000, 20, nf2, ni2, f2);
    chk("t3_feita", nf + nf2, 0);
    chk("t3_inval", ni + ni2, 1);
    chk("t3_jogada", jogada, 4'b0001);

    // button held while arming
    run(0, 4'b0000, 3, nf, ni, first);
    run(0, 4'b1000, 12, nf, ni, first);
    step(1, 4'b1000);
    chk("t4_guard", db_estado, 1);
    run(1, 4'b1000, 5, nf, ni, first);
    run(1, 4'b0000, 20, nf2, ni2, f2);
    chk("t4_nopulse", nf + ni + nf2 + ni2, 0);
    chk("t4_ready", db_estado, 2);
    run(1, 4'b0010, 12, nf, ni, first);
    run(1, 4'b0000, 20, nf2, ni2, f2);
    chk("t4_npulse", nf + nf2, 1);
    chk("t4_jogada", jogada, 4'b0010);

    // habilita dropped while waiting for release
    run(1, 4'b0100, 12, nf, ni, first);
    chk("t5_solta", db_estado, 4);
    step(0, 4'b0100);
    chk("t5_abort", db_estado, 0);
    run(0, 4'b0000, 20, nf, ni, first);
    chk("t5_nopulse", nf + ni, 0);
    chk("t5_jogada_kept", jogada, 4'b0100);
    run(1, 4'b0000, 3, nf, ni, first);

    // reset while emitting
    run(1, 4'b1000, 12, nf, ni, first);
    first = 0;
    for (int k = 1; k <= 20 && first == 0; k++) begin
      step(1, 4'b0000);
      if (db_estado == 4'd5) first = k;
    end
    chk("t6_reach_emite", (first != 0) ? 1 : 0, 1);
    reset = 1'b1;
    #1;
    chk("t6_feita", jogada_feita, 0);
    chk("t6_jogada", jogada, 0);
    chk("t6_estado", db_estado, 0);
    check_all();
    @(negedge clock);
    reset = 1'b0;
    check_all();
    run(1, 4'b0000, 20, nf, ni, first);
    chk("t6_nopulse", nf + ni, 0);

    // random traffic
    repeat (250) begin
      logic       h;
      logic [3:0] b;
      int         r;
      h = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 6);
      case (r)
        0, 1:    b = 4'b0000;
        2, 3, 4: b = 4'b0001 << $urandom_range(0, 3);
        5:       b = (4'b0001 << $urandom_range(0, 3)) | (4'b0001 << $urandom_range(0, 3));
        default: b = 4'($urandom_range(0, 15));
      endcase
      run(h, b, $urandom_range(1, 12), nf, ni, first);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
